philo_waiter: RTL and testbench
===============================

# philo_waiter

Centralized fork arbiter for a ring of N philosophers: the responder side of the hungry/eat protocol. Each philosopher raises `hungry` and holds it until the waiter grants `eat`. The waiter owns all N forks and grants a philosopher both adjacent forks atomically. Rotating priority prevents starvation. Sits beside the philosopher ring in the `philo*` tops and replaces the neighbour-state polling used by the decentralized model.

## Interface
- `N`, 5: number of philosophers and forks; legal range 2..64.
- `AGE_LIMIT`, 15: wait cycles before a hungry philosopher becomes urgent; used only with `WAITER_AGING_EN`.
- `clk`  input  1  clock; all state updates on posedge.
- `reset`  input  1  synchronous, active-high.
- `hungry`  input  N  bit i: philosopher i requests to eat; level, held until `eat[i]`.
- `done`  input  N  bit i: one-cycle pulse, philosopher i releases both forks.
- `eat`  output  N  bit i: registered grant; high from grant until the cycle after `done[i]`.
- `fork_held`  output  N  bit k: fork k is in use. Fork i is philosopher i's left fork, fork (i+1) mod N is its right fork.
- `urgent`  output  N  bit i: philosopher i has exceeded `AGE_LIMIT`; constant 0 without `WAITER_AGING_EN`.

## Operation
- Per-philosopher state: THINKING, HUNGRY, EATING. Reset value is THINKING.
- THINKING→HUNGRY when `hungry[i]`=1.
- HUNGRY→EATING when granted.
- EATING→THINKING when `done[i]`=1.
- HUNGRY→THINKING if `hungry[i]` drops before a grant (withdrawal). This is legal and frees nothing.
- Grant scan each cycle:
  - Visit i = ptr, ptr+1, …, ptr+N-1 (mod N).
  - Grant i if it is HUNGRY, fork i and fork (i+1) mod N are free in the registered `fork_held`, and neither fork was claimed earlier in the same scan.
  - Multiple non-adjacent grants per cycle are allowed.
- `ptr` (width clog2(N)): after a cycle with at least one grant, ptr = (last granted index in scan order + 1) mod N. Otherwise ptr is unchanged. Reset value is 0.
- `fork_held[k]` is set on grant to either neighbour. It is cleared on `done` from the holder.
- Invariant: `eat[i]` and `eat[(i+1) mod N]` are never both 1.
- Boundary cases:
  - `done[i]` while not EATING: ignored.
  - `hungry[i]` and `done[i]` in the same cycle while EATING: release is processed; the request is seen next cycle.
  - N=2: both philosophers share both forks, so at most one eats.
  - Wrap: philosopher N-1 uses forks N-1 and 0.
  - All N hungry at once: grants follow ptr order. Maximum concurrent eaters is floor(N/2).
- Reset mid-operation: every state returns to THINKING. `eat`, `fork_held`, `urgent`, `ptr` and age counters all clear on the next edge. Outstanding meals are dropped silently.

## Timing
- Grant latency: `hungry[i]` first high at edge t with forks free and top priority → `eat[i]`=1 after edge t+1.
- Release: `done[i]` at edge t → `eat[i]`=0 and forks free after edge t+1. A neighbour can be granted no earlier than edge t+2, because the scan reads registered `fork_held` only.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `WAITER_AGING_EN` defined:
  - Each philosopher has a saturating wait counter that increments while HUNGRY and clears otherwise.
  - At count ≥ `AGE_LIMIT`, `urgent[i]`=1. Philosophers i-1 and i+1 (mod N) are then excluded from new grants until i is granted.
  - If two adjacent philosophers are both urgent, the lower index wins.
- `WAITER_AGING_EN` undefined: no counters exist, `urgent` is tied to 0, and the rotating pointer is the only fairness mechanism.

## Structure
- The shared package `philo_pkg` holds the philosopher state enum (THINKING, READING, EATING, HUNGRY, shared with `philosopher`), a `NEXT(i,N)`/`PREV(i,N)` modular-index helper, and the default `AGE_LIMIT`.
- One sub-module, `waiter_grant_scan`: combinational rotating scan. Inputs are the HUNGRY vector, `fork_held`, ptr and the urgent mask. Outputs are the grant vector and the next ptr.

## Test plan
- N=5, reset, then `hungry`=5'b00001 → `eat`=5'b00001 one cycle later; `fork_held`=5'b00011; ptr=1.
- N=5, all `hungry`=5'b11111 from reset → first-cycle `eat`=5'b00101 (grants 0 and 2); ptr=3; adjacent `eat` bits are never both set across 1000 random cycles.
- Philosopher 1 eating, `done[1]` pulse at edge t, with `hungry[2]` held → `eat[1]`=0 after t+1; `eat[2]`=1 after t+2.
- `done[3]` pulse while philosopher 3 is THINKING → no change to `eat` or `fork_held`.
- Reset asserted while `eat`=5'b01010 → all outputs 0 and ptr=0 next cycle; `hungry`=5'b00100 then yields `eat[2]` after one cycle.
- `WAITER_AGING_EN`, N=5, `AGE_LIMIT`=4: philosophers 0 and 2 repeatedly re-request while 1 stays hungry → `urgent[1]`=1 after 4 waiting cycles; 0 and 2 are not re-granted; `eat[1]`=1 within 2 cycles of both releasing.

Source files
------------

// File: rtl/philo_pkg.sv
// Shared philosopher definitions: state enum, ring-index helpers and the default aging limit.
package philo_pkg;

  typedef enum logic [1:0] {
    THINKING,
    READING,
    EATING,
    HUNGRY
  } philo_state_e;

  localparam int DEFAULT_AGE_LIMIT = 15;

  function automatic int NEXT(input int i, input int n);
    return (i >= n - 1) ? 0 : i + 1;
  endfunction

  function automatic int PREV(input int i, input int n);
    return (i == 0) ? n - 1 : i - 1;
  endfunction

endpackage

// File: rtl/philo_waiter_if.sv
// Philosopher ring <-> waiter bundle; the master side is the ring, the slave side is the waiter.
interface philo_waiter_if #(
  parameter int N = 5
);
  logic [N-1:0] hungry;
  logic [N-1:0] done;
  logic [N-1:0] eat;
  logic [N-1:0] fork_held;
  logic [N-1:0] urgent;

  modport master (
    output hungry,
    output done,
    input  eat,
    input  fork_held,
    input  urgent
  );

  modport slave (
    input  hungry,
    input  done,
    output eat,
    output fork_held,
    output urgent
  );
endinterface

// File: rtl/waiter_grant_scan.sv
// Combinational rotating grant scan: walks the ring from ptr and hands out non-conflicting fork pairs.
import philo_pkg::*;

module waiter_grant_scan #(
  parameter int N  = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  fork_held_i,
  input  logic [N-1:0]  urgent_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] ptr_o
);

  logic [N-1:0] block;
  logic [N-1:0] claimed;
  int           idx;
  int           nxt;

  // An urgent neighbour locks a philosopher out, unless that philosopher is
  // itself urgent and has the lower index (lower index wins a tie).
  always_comb begin
    block = '0;
    for (int i = 0; i < N; i++) begin
      block[i] = (urgent_i[PREV(i, N)] && !(urgent_i[i] && i < PREV(i, N)))
              || (urgent_i[NEXT(i, N)] && !(urgent_i[i] && i < NEXT(i, N)));
    end
  end

  // NOTE: every combinational output gets a default first so no path through the scan can infer a latch.
  always_comb begin
    claimed = '0;
    grant_o = '0;
    ptr_o   = ptr_i;
    idx     = 0;
    nxt     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx -= N;
      nxt = NEXT(idx, N);
      if (req_i[idx] && !block[idx]
          && !fork_held_i[idx] && !fork_held_i[nxt]
          && !claimed[idx] && !claimed[nxt]) begin
        grant_o[idx] = 1'b1;
        claimed[idx] = 1'b1;
        claimed[nxt] = 1'b1;
        ptr_o        = PW'(nxt);
      end
    end
  end

endmodule

// File: rtl/philo_waiter.sv
// Centralized fork waiter for a ring of N philosophers with rotating priority.
// Optional starvation aging is enabled by defining WAITER_AGING_EN.
import philo_pkg::*;

module philo_waiter #(
  parameter int N = 5
`ifdef WAITER_AGING_EN
  ,
  parameter int AGE_LIMIT = DEFAULT_AGE_LIMIT
`endif
) (
  input  logic         clk,
  input  logic         reset,
  philo_waiter_if.slave bus
);

  localparam int PW = $clog2(N);

  philo_state_e  st_q [N];
  philo_state_e  st_d [N];
  logic [N-1:0]  eat_q, eat_d;
  logic [N-1:0]  fork_q, fork_d;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [N-1:0]  urgent;
  logic [PW-1:0] ptr_q, ptr_d;

  // Requests come straight from the hungry level so a free philosopher is granted on the first edge it asks.
  always_comb begin
    for (int i = 0; i < N; i++) req[i] = bus.hungry[i] && (st_q[i] != EATING);
  end

  waiter_grant_scan #(
    .N  (N),
    .PW (PW)
  ) u_scan (
    .req_i       (req),
    .fork_held_i (fork_q),
    .urgent_i    (urgent),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .ptr_o       (ptr_d)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        EATING: if (bus.done[i]) st_d[i] = THINKING;
        default: begin
          if (grant[i])            st_d[i] = EATING;
          else if (bus.hungry[i])  st_d[i] = HUNGRY;
          else                     st_d[i] = THINKING;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) eat_d[i] = (st_d[i] == EATING);
    for (int k = 0; k < N; k++) fork_d[k] = eat_d[k] | eat_d[PREV(k, N)];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the per-philosopher state array is a handful of flops, so it is reset like any other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) st_q[i] <= THINKING;
      eat_q  <= '0;
      fork_q <= '0;
      ptr_q  <= '0;
    end else begin
      for (int i = 0; i < N; i++) st_q[i] <= st_d[i];
      eat_q  <= eat_d;
      fork_q <= fork_d;
      ptr_q  <= ptr_d;
    end
  end

`ifdef WAITER_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);

  logic [AW-1:0] age_q [N];

  // Counts consecutive edges spent waiting; saturates at the limit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset || st_d[i] != HUNGRY)        age_q[i] <= '0;
      else if (age_q[i] != AW'(AGE_LIMIT))   age_q[i] <= age_q[i] + AW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) urgent[i] = (age_q[i] == AW'(AGE_LIMIT));
  end
`else
  assign urgent = '0;
`endif

  assign bus.eat       = eat_q;
  assign bus.fork_held = fork_q;
  assign bus.urgent    = urgent;

endmodule

// File: tb/tb_philo_waiter.sv
// Self-checking bench for philo_waiter (N=5): a fork-ownership model checked every cycle plus directed literal checks.
module tb_philo_waiter;

  localparam int N   = 5;
  localparam int LIM = 4;
`ifdef WAITER_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  philo_waiter_if #(.N(N)) bus ();

  philo_waiter #(
    .N (N)
`ifdef WAITER_AGING_EN
    ,
    .AGE_LIMIT (LIM)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: who is eating, the rotating start point, and how long each philosopher has waited.
  bit [N-1:0] m_eat = '0;
  int         m_ptr = 0;
  int         m_wait [N];
  bit         started = 1'b0;

  function automatic bit [N-1:0] forks_of(input bit [N-1:0] e);
    bit [N-1:0] f;
    for (int k = 0; k < N; k++) f[k] = e[k] | e[(k + N - 1) % N];
    return f;
  endfunction

  function automatic bit [N-1:0] urgent_of(input int w [N]);
    bit [N-1:0] u;
    for (int k = 0; k < N; k++) u[k] = AGING && (w[k] >= LIM);
    return u;
  endfunction

  function automatic bit blocked(input bit [N-1:0] u, input int i);
    int l, r;
    l = (i + N - 1) % N;
    r = (i + 1) % N;
    return (u[l] && !(u[i] && i < l)) || (u[r] && !(u[i] && i < r));
  endfunction

  always @(posedge clk) begin
    bit [N-1:0] nxt_eat, busy, u;
    int         p, i, j;
    int         nw [N];
    started <= 1'b1;
    if (reset) begin
      m_eat <= '0;
      m_ptr <= 0;
      for (int k = 0; k < N; k++) m_wait[k] <= 0;
    end else begin
      u       = urgent_of(m_wait);
      busy    = forks_of(m_eat);
      nxt_eat = m_eat & ~bus.done;
      p       = m_ptr;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        j = (i + 1) % N;
        if (bus.hungry[i] && !m_eat[i] && !busy[i] && !busy[j] && !blocked(u, i)) begin
          nxt_eat[i] = 1'b1;
          busy[i]    = 1'b1;
          busy[j]    = 1'b1;
          p          = j;
        end
      end
      for (int k = 0; k < N; k++)
        nw[k] = (bus.hungry[k] && !m_eat[k] && !nxt_eat[k]) ? ((m_wait[k] >= LIM) ? LIM : m_wait[k] + 1) : 0;
      m_eat <= nxt_eat;
      m_ptr <= p;
      for (int k = 0; k < N; k++) m_wait[k] <= nw[k];
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("eat",       64'(bus.eat),       64'(m_eat));
      check("fork_held", 64'(bus.fork_held), 64'(forks_of(m_eat)));
      check("urgent",    64'(bus.urgent),    64'(urgent_of(m_wait)));
      check("ptr",       64'(dut.ptr_q),     64'(m_ptr));
      check("adjacent",  64'(bus.eat & {bus.eat[0], bus.eat[N-1:1]}), 64'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hungry = '0;
    bus.done   = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_eat",  64'(bus.eat),       64'(0));
    check("rst_fork", 64'(bus.fork_held), 64'(0));
    check("rst_ptr",  64'(dut.ptr_q),     64'(0));

    // Single request from philosopher 0
    bus.hungry = 5'b00001; tick();
    check("p0_eat",  64'(bus.eat),       64'(5'b00001));
    check("p0_fork", 64'(bus.fork_held), 64'(5'b00011));
    check("p0_ptr",  64'(dut.ptr_q),     64'(1));
    bus.hungry = '0; bus.done = 5'b00001; tick(); bus.done = '0;
    check("p0_rel", 64'(bus.eat), 64'(0));

    // Everyone hungry straight out of reset
    reset = 1'b1; tick();
    reset = 1'b0; bus.hungry = 5'b11111; tick();
    check("all_eat", 64'(bus.eat),       64'(5'b00101));
    check("all_ptr", 64'(dut.ptr_q),     64'(3));
    check("all_fork",64'(bus.fork_held), 64'(5'b01111));
    bus.hungry = 5'b11010; tick();
    check("all_hold", 64'(bus.eat), 64'(5'b00101));
    bus.done = 5'b00101; tick(); bus.done = '0;
    check("all_rel",  64'(bus.eat),       64'(0));
    check("all_relf", 64'(bus.fork_held), 64'(0));
    tick();
    check("all_2nd",  64'(bus.eat),   64'(5'b01010));
    check("all_ptr2", 64'(dut.ptr_q), 64'(2));

    // done from a thinking philosopher is ignored
    bus.done = 5'b00001; tick(); bus.done = '0;
    check("ign_eat",  64'(bus.eat),       64'(5'b01010));
    check("ign_fork", 64'(bus.fork_held), 64'(5'b11110));

    // Reset mid-meal, then a fresh request
    reset = 1'b1; tick();
    check("mid_eat",  64'(bus.eat),       64'(0));
    check("mid_fork", 64'(bus.fork_held), 64'(0));
    check("mid_ptr",  64'(dut.ptr_q),     64'(0));
    reset = 1'b0; bus.hungry = 5'b00100; tick();
    check("mid_p2", 64'(bus.eat), 64'(5'b00100));

    // Hand-off from philosopher 1 to neighbour 2
    bus.hungry = '0; bus.done = 5'b00100; tick(); bus.done = '0;
    bus.hungry = 5'b00010; tick();
    check("ho_p1", 64'(bus.eat), 64'(5'b00010));
    bus.hungry = 5'b00100; tick();
    check("ho_wait", 64'(bus.eat), 64'(5'b00010));
    bus.done = 5'b00010; tick(); bus.done = '0;
    check("ho_rel", 64'(bus.eat), 64'(0));
    tick();
    check("ho_p2", 64'(bus.eat), 64'(5'b00100));

    // hungry and done together while eating: release first, request next cycle
    bus.done = 5'b00100; tick(); bus.done = '0;
    check("hd_rel", 64'(bus.eat), 64'(0));
    tick();
    check("hd_regrant", 64'(bus.eat), 64'(5'b00100));

    // Wrap: philosopher 4 takes forks 4 and 0
    bus.hungry = '0; bus.done = 5'b00100; tick(); bus.done = '0;
    bus.hungry = 5'b10000; tick();
    check("wrap_eat",  64'(bus.eat),       64'(5'b10000));
    check("wrap_fork", 64'(bus.fork_held), 64'(5'b10001));
    bus.hungry = '0; bus.done = 5'b10000; tick(); bus.done = '0;

`ifdef WAITER_AGING_EN
    begin
      bit seen;
      seen = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      bus.hungry = 5'b00111; tick();
      check("age_first", 64'(bus.eat), 64'(5'b00101));
      for (int it = 0; it < 8 && !seen; it++) begin
        bus.done = 5'b00101; tick(); bus.done = '0;
        if (bus.urgent[1]) seen = 1'b1;
        else tick();
      end
      check("age_urgent", 64'(bus.urgent), 64'(5'b00010));
      tick();
      check("age_p1", 64'(bus.eat), 64'(5'b00010));
      bus.hungry = '0; bus.done = 5'b00010; tick(); bus.done = '0;
    end
`endif

    // Random traffic, with one reset in the middle
    for (int c = 0; c < 1000; c++) begin
      bus.hungry = N'($urandom);
      bus.done   = N'($urandom & $urandom);
      reset      = (c == 500);
      tick();
    end
    reset = 1'b0;
    bus.hungry = '0;
    bus.done   = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
